// File: rtl/floor_call_panel.sv
// floor_call_panel: per-floor call buttons are synchronized, debounced and
// tracked through IDLE -> PENDING -> SERVING, driving steady/blinking LED
// enables and the lowest-index pending floor for the car controller.
module floor_call_panel #(
    parameter int N_FLOORS        = 4,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int SERVE_CYCLES    = 100_000_000
) (
    input  logic                                               clk,
    input  logic                                               rst_n,
    input  logic [N_FLOORS-1:0]                                btn,
    input  logic [((N_FLOORS > 1) ? $clog2(N_FLOORS) : 1)-1:0] cur_floor,
    input  logic                                               at_floor,
    output logic [N_FLOORS-1:0]                                enable_fijo,
    output logic [N_FLOORS-1:0]                                enable_inter,
    output logic                                               next_valid,
    output logic [((N_FLOORS > 1) ? $clog2(N_FLOORS) : 1)-1:0] next_floor
);

    localparam int FW = (N_FLOORS > 1) ? $clog2(N_FLOORS) : 1;
    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int SW = (SERVE_CYCLES > 1) ? $clog2(SERVE_CYCLES) : 1;
    localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [SW-1:0] SRV_LAST = SW'(SERVE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_SERVING = 2'd2
    } state_e;

    logic [N_FLOORS-1:0] sync1_q, sync1_d;
    logic [N_FLOORS-1:0] sync2_q, sync2_d;
    logic [N_FLOORS-1:0] db_lvl_q, db_lvl_d;
    logic [DW-1:0]       db_cnt_q  [N_FLOORS];
    logic [DW-1:0]       db_cnt_d  [N_FLOORS];
    logic [SW-1:0]       srv_cnt_q [N_FLOORS];
    logic [SW-1:0]       srv_cnt_d [N_FLOORS];
    state_e              state_q   [N_FLOORS];
    state_e              state_d   [N_FLOORS];
    logic [N_FLOORS-1:0] press;
    logic [N_FLOORS-1:0] fijo_q, fijo_d;
    logic [N_FLOORS-1:0] inter_q, inter_d;
    logic                next_valid_q, next_valid_d;
    logic [FW-1:0]       next_floor_q, next_floor_d;
    logic                found;

    // Two-flop synchronizer and per-floor debounce; a press is the cycle the
    // debounced level rises.
    always_comb begin
        sync1_d = btn;
        sync2_d = sync1_q;
        db_lvl_d = db_lvl_q;
        press = '0;
        for (int unsigned i = 0; i < N_FLOORS; i++) begin
            db_cnt_d[i] = '0;
            if (sync2_q[i] != db_lvl_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    db_lvl_d[i] = sync2_q[i];
                    press[i]    = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Per-floor call FSM next state and serve timer.
    always_comb begin
        for (int unsigned i = 0; i < N_FLOORS; i++) begin
            state_d[i]   = state_q[i];
            srv_cnt_d[i] = srv_cnt_q[i];
            case (state_q[i])
                ST_IDLE: begin
                    if (press[i]) begin
                        if (at_floor && (cur_floor == FW'(i))) begin
                            state_d[i]   = ST_SERVING;
                            srv_cnt_d[i] = '0;
                        end else begin
                            state_d[i] = ST_PENDING;
                        end
                    end
                end
                ST_PENDING: begin
                    if (at_floor && (cur_floor == FW'(i))) begin
                        state_d[i]   = ST_SERVING;
                        srv_cnt_d[i] = '0;
                    end
                end
                ST_SERVING: begin
                    if (srv_cnt_q[i] == SRV_LAST) begin
                        state_d[i]   = ST_IDLE;
                        srv_cnt_d[i] = '0;
                    end else begin
                        srv_cnt_d[i] = srv_cnt_q[i] + 1'b1;
                    end
                end
                default: begin
                    state_d[i]   = ST_IDLE;
                    srv_cnt_d[i] = '0;
                end
            endcase
        end
    end

    // Output decode of the current state, registered; lowest pending floor wins.
    always_comb begin
        fijo_d       = '0;
        inter_d      = '0;
        next_floor_d = '0;
        found        = 1'b0;
        for (int unsigned i = 0; i < N_FLOORS; i++) begin
            fijo_d[i]  = (state_q[i] == ST_PENDING);
            inter_d[i] = (state_q[i] == ST_SERVING);
        end
        next_valid_d = |fijo_d;
        for (int unsigned i = 0; i < N_FLOORS; i++) begin
            if (!found && fijo_d[i]) begin
                next_floor_d = FW'(i);
                found        = 1'b1;
            end
        end
    end

    // State registers, all cleared asynchronously by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            db_lvl_q     <= '0;
            fijo_q       <= '0;
            inter_q      <= '0;
            next_valid_q <= 1'b0;
            next_floor_q <= '0;
            for (int unsigned i = 0; i < N_FLOORS; i++) begin
                db_cnt_q[i]  <= '0;
                srv_cnt_q[i] <= '0;
                state_q[i]   <= ST_IDLE;
            end
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            db_lvl_q     <= db_lvl_d;
            fijo_q       <= fijo_d;
            inter_q      <= inter_d;
            next_valid_q <= next_valid_d;
            next_floor_q <= next_floor_d;
            for (int unsigned i = 0; i < N_FLOORS; i++) begin
                db_cnt_q[i]  <= db_cnt_d[i];
                srv_cnt_q[i] <= srv_cnt_d[i];
                state_q[i]   <= state_d[i];
            end
        end
    end

    assign enable_fijo  = fijo_q;
    assign enable_inter = inter_q;
    assign next_valid   = next_valid_q;
    assign next_floor   = next_floor_q;

endmodule

// File: tb/tb_floor_call_panel.sv
// Testbench for floor_call_panel: directed scenarios plus random buttons,
// every cycle compared against a behavioural model of the call panel.
module tb_floor_call_panel;

    localparam int NF = 4;
    localparam int DB = 4;
    localparam int SV = 10;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NF-1:0] btn;
    logic [1:0]    cur_floor;
    logic          at_floor;
    logic [NF-1:0] enable_fijo;
    logic [NF-1:0] enable_inter;
    logic          next_valid;
    logic [1:0]    next_floor;

    int checks   = 0;
    int failures = 0;

    // Model state: synchronizer stages, debounced level, run of differing
    // samples, call state (0 idle, 1 waiting, 2 being served), serve time left.
    bit [NF-1:0] m_s1, m_s2, m_lvl;
    int          m_run  [NF];
    int          m_st   [NF];
    int          m_left [NF];
    bit [NF-1:0] e_fijo, e_inter;
    bit          e_nv;
    int          e_nf;

    int inter0_cnt;
    int fijo0_seen;

    floor_call_panel #(
        .N_FLOORS       (NF),
        .DEBOUNCE_CYCLES(DB),
        .SERVE_CYCLES   (SV)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn         (btn),
        .cur_floor   (cur_floor),
        .at_floor    (at_floor),
        .enable_fijo (enable_fijo),
        .enable_inter(enable_inter),
        .next_valid  (next_valid),
        .next_floor  (next_floor)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_lvl = '0;
        e_fijo = '0; e_inter = '0; e_nv = 1'b0; e_nf = 0;
        for (int i = 0; i < NF; i++) begin
            m_run[i] = 0; m_st[i] = 0; m_left[i] = 0;
        end
    endtask

    task automatic model_edge();
        bit press;
        bit here;
        e_fijo = '0; e_inter = '0; e_nf = 0;
        for (int i = NF - 1; i >= 0; i--) begin
            e_fijo[i]  = (m_st[i] == 1);
            e_inter[i] = (m_st[i] == 2);
            if (m_st[i] == 1) e_nf = i;
        end
        e_nv = (e_fijo != 0);
        for (int i = 0; i < NF; i++) begin
            press = 1'b0;
            if (m_s2[i] != m_lvl[i]) begin
                m_run[i]++;
                if (m_run[i] == DB) begin
                    m_lvl[i] = m_s2[i];
                    m_run[i] = 0;
                    press = m_s2[i];
                end
            end else begin
                m_run[i] = 0;
            end
            here = at_floor && (int'(cur_floor) == i);
            if (m_st[i] == 2) begin
                m_left[i]--;
                if (m_left[i] == 0) m_st[i] = 0;
            end else if (m_st[i] == 1) begin
                if (here) begin m_st[i] = 2; m_left[i] = SV; end
            end else if (press) begin
                if (here) begin m_st[i] = 2; m_left[i] = SV; end
                else m_st[i] = 1;
            end
        end
        m_s2 = m_s1;
        m_s1 = btn;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("fijo", 32'(enable_fijo), 32'(e_fijo));
        check("inter", 32'(enable_inter), 32'(e_inter));
        check("next_valid", 32'(next_valid), 32'(e_nv));
        check("next_floor", 32'(next_floor), 32'(e_nf));
        check("exclusive", 32'(enable_fijo & enable_inter), 32'd0);
        if (enable_inter[0]) inter0_cnt++;
        if (enable_fijo[0]) fijo0_seen++;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    // Called at a falling edge; reset pulse lands between clock edges.
    task automatic reset_pulse();
        #1 rst_n = 1'b0;
        #1;
        check("rst_fijo", 32'(enable_fijo), 32'd0);
        check("rst_inter", 32'(enable_inter), 32'd0);
        check("rst_nv", 32'(next_valid), 32'd0);
        check("rst_nf", 32'(next_floor), 32'd0);
        model_reset();
        #1 rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; btn = '0; cur_floor = '0; at_floor = 1'b0;
        model_reset();
        @(negedge clk);
        reset_pulse();

        // Press floor 2, hold, then release
        btn = 4'b0100;
        run(8);
        check("press_fijo", 32'(enable_fijo), 32'h4);
        check("press_nf", 32'(next_floor), 32'd2);
        btn = '0;
        run(10);

        // Bounce on floor 1
        for (int k = 0; k < 10; k++) begin
            btn[1] = ~btn[1];
            run(2);
        end
        btn = '0;
        run(8);

        // Serve floor 2
        cur_floor = 2'd2; at_floor = 1'b1;
        run(14);
        at_floor = 1'b0;
        run(2);
        check("served_nv", 32'(next_valid), 32'd0);

        // Priority between floors 1 and 3
        cur_floor = 2'd0;
        btn = 4'b1010;
        run(9);
        btn = '0;
        check("prio_first", 32'(next_floor), 32'd1);
        cur_floor = 2'd1; at_floor = 1'b1;
        run(2);
        at_floor = 1'b0;
        run(3);
        check("prio_second", 32'(next_floor), 32'd3);
        cur_floor = 2'd3; at_floor = 1'b1;
        run(14);
        at_floor = 1'b0;

        // Press at the current floor, with a re-press during service
        run(8);
        inter0_cnt = 0; fijo0_seen = 0;
        cur_floor = 2'd0; at_floor = 1'b1;
        btn = 4'b0001; run(4);
        btn = 4'b0000; run(4);
        btn = 4'b0001; run(6);
        btn = 4'b0000; run(16);
        check("here_serve_len", 32'(inter0_cnt), 32'(SV));
        check("here_no_fijo", 32'(fijo0_seen), 32'd0);
        at_floor = 1'b0;
        run(8);

        // Reset while floor 0 waits and floor 3 is being served
        btn = 4'b1001; cur_floor = 2'd2;
        run(8);
        btn = '0; cur_floor = 2'd3; at_floor = 1'b1;
        run(3);
        at_floor = 1'b0;
        check("pre_rst_state", 32'({enable_fijo, enable_inter}), 32'h18);
        reset_pulse();
        run(12);

        // Button held through reset release
        btn = 4'b0010;
        @(negedge clk);
        reset_pulse();
        run(9);
        check("held_press", 32'(enable_fijo), 32'h2);
        btn = '0;
        run(8);

        // Random traffic
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 5) == 0) btn[$urandom_range(0, NF - 1)] ^= 1'b1;
            if ($urandom_range(0, 7) == 0) cur_floor = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 5) == 0) at_floor = ~at_floor;
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
